// File: rtl/key_arbiter_if.sv
// ---------------------------------------------------------------------------
// key_arbiter_if
// Bundle between the 10-key arbiter and its surroundings.
//   key   : raw active-high key lines 0..9 (asynchronous to the arbiter clock)
//   ack   : consumer accepts the presented digit (only honoured while valid=1)
//   gnt   : one-hot grant, feeds the decimal-to-binary encoder inputs d0..d9
//   code  : binary code of the granted digit (0..9)
//   valid : gnt/code hold an accepted digit
//   multi : more than one key was down when the current winner was picked
//   busy  : arbiter is not idle
// master = keypad/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface key_arbiter_if;
    logic [9:0] key;
    logic       ack;
    logic [9:0] gnt;
    logic [3:0] code;
    logic       valid;
    logic       multi;
    logic       busy;

    modport master (
        output key,
        output ack,
        input  gnt,
        input  code,
        input  valid,
        input  multi,
        input  busy
    );

    modport slave (
        input  key,
        input  ack,
        output gnt,
        output code,
        output valid,
        output multi,
        output busy
    );
endinterface

// File: rtl/key_arbiter.sv
// ---------------------------------------------------------------------------
// key_arbiter
// Debouncing, round-robin arbiter for ten decimal keys. A pressed key is
// synchronized, debounced for DEB_N cycles, then presented as a one-hot grant
// plus binary code until acknowledged. The key must then be released for
// DEB_N consecutive cycles before a new press is considered.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : key_arbiter_if.slave (key, ack in; gnt, code, valid, multi, busy out)
// Parameter:
//   DEB_N : debounce length in clock cycles, legal range 1..15
// ---------------------------------------------------------------------------
module key_arbiter #(
    parameter int DEB_N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    key_arbiter_if.slave  bus
);

    localparam logic [3:0] CNT_LAST = 4'(DEB_N - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic [9:0] key_meta_reg;
    logic [9:0] key_sync_reg;
    logic [3:0] cand_reg, cand_next;
    logic [3:0] ptr_reg, ptr_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       multi_reg, multi_next;

    logic [9:0] cand_onehot;
    logic       cand_key;
    logic [9:0] key_rot;
    logic [3:0] scan_off;
    logic [4:0] scan_sum;
    logic [3:0] scan_pick;
    logic       valid;

    genvar gi;

    // One-hot copy of the candidate: used both to sample its synchronized key
    // and to drive the grant vector without an out-of-range index.
    generate
        for (gi = 0; gi < 10; gi++) begin : g_cand_dec
            assign cand_onehot[gi] = (cand_reg == 4'(gi));
        end
    endgenerate

    assign cand_key = |(key_sync_reg & cand_onehot);

    // Round-robin scan: rotate the synchronized keys so bit 0 corresponds to
    // ptr, take the lowest set bit, then map the offset back modulo 10.
    // ptr is always 0..9, so the doubled vector covers every rotation.
    always_comb begin
        key_rot  = 10'({key_sync_reg, key_sync_reg} >> ptr_reg);
        scan_off = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (key_rot[i]) begin
                scan_off = 4'(i);
            end
        end
        scan_sum  = 5'(ptr_reg) + 5'(scan_off);
        scan_pick = (scan_sum >= 5'd10) ? 4'(scan_sum - 5'd10) : scan_sum[3:0];
    end

    // Two-flop synchronizer for the asynchronous key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_reg <= '0;
            key_sync_reg <= '0;
        end else begin
            key_meta_reg <= bus.key;
            key_sync_reg <= key_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            multi_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            multi_reg <= multi_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        multi_next = multi_reg;
        case (state_reg)
            IDLE: begin
                if (|key_sync_reg) begin
                    cand_next  = scan_pick;
                    // x & (x-1) clears the lowest set bit: nonzero means 2+ keys.
                    multi_next = |(key_sync_reg & (key_sync_reg - 10'd1));
                    cnt_next   = 4'd0;
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!cand_key) begin
                    state_next = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HOLD: begin
                if (bus.ack) begin
                    ptr_next   = (cand_reg == 4'd9) ? 4'd0 : cand_reg + 4'd1;
                    cnt_next   = 4'd0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // Only the granted key matters here; any bounce back high
                // restarts the release window.
                if (cand_key) begin
                    cnt_next = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                    if (cnt_reg == CNT_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registers only, so the asynchronous reset
    // clears them immediately.
    assign valid     = (state_reg == HOLD);
    assign bus.valid = valid;
    assign bus.busy  = (state_reg != IDLE);
    assign bus.code  = valid ? cand_reg : 4'd0;
    assign bus.multi = multi_reg;

    generate
        for (gi = 0; gi < 10; gi++) begin : g_gnt
            assign bus.gnt[gi] = valid & cand_onehot[gi];
        end
    endgenerate

endmodule

// File: tb/tb_key_arbiter.sv
// ---------------------------------------------------------------------------
// tb_key_arbiter
// Self-checking bench for key_arbiter (DEB_N=4). Expected grants are pushed
// to a scoreboard queue when a press is driven and popped when VALID rises.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_key_arbiter;

    localparam int DEB_N = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_arbiter_if bus ();

    key_arbiter #(.DEB_N(DEB_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic       multi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts rising edges until VALID is seen (bounded).
    task automatic wait_valid(input int max_edges, output int edges);
        edges = 0;
        while (bus.valid !== 1'b1 && edges < max_edges) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Counts rising edges until BUSY drops (bounded).
    task automatic wait_idle(input int max_edges, output int edges);
        edges = 0;
        while (bus.busy !== 1'b0 && edges < max_edges) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.key = '0;
        bus.ack = 1'b0;
        step(2);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.gnt !== 10'h000) begin errors++; $display("FAIL reset_gnt: got %03h want 000", bus.gnt); end
        checks++; if (bus.code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", bus.code); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.multi !== 1'b0) begin errors++; $display("FAIL reset_multi: got %b want 0", bus.multi); end
        rst_n = 1'b1;
        step(2);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
        $display("reset: outputs cleared");
    endtask

    task automatic test_single_press();
        int   edges;
        exp_t e;
        bus.key = 10'h008;
        exp_q.push_back('{code: 4'd3, multi: 1'b0});
        wait_valid(40, edges);
        e = exp_q.pop_front();
        checks++; if (edges !== DEB_N + 3) begin errors++; $display("FAIL single_latency: got %0d edges want %0d", edges, DEB_N + 3); end
        checks++; if (bus.gnt !== (10'd1 << e.code)) begin errors++; $display("FAIL single_gnt: got %03h want %03h", bus.gnt, 10'd1 << e.code); end
        checks++; if (bus.code !== e.code) begin errors++; $display("FAIL single_code: got %0d want %0d", bus.code, e.code); end
        checks++; if (bus.multi !== e.multi) begin errors++; $display("FAIL single_multi: got %b want %b", bus.multi, e.multi); end
        $display("grant: code=%0d gnt=%03h multi=%b latency=%0d", bus.code, bus.gnt, bus.multi, edges);
        step(2);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL single_hold_valid: got %b want 1", bus.valid); end
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        checks++; if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL single_ack: got valid=%b busy=%b want valid=0 busy=1", bus.valid, bus.busy); end
        bus.key = '0;
        // Two synchronizer edges plus DEB_N low cycles in RELEASE.
        wait_idle(40, edges);
        checks++; if (edges !== DEB_N + 2) begin errors++; $display("FAIL single_release: got %0d edges want %0d", edges, DEB_N + 2); end
        $display("release: idle after %0d edges", edges);
    endtask

    task automatic test_short_press();
        int   edges;
        bit   seen;
        exp_t e;
        bus.key = 10'h020;
        step(3);
        bus.key = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL short_valid: got valid seen=%b want 0", seen); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b want 0", bus.busy); end
        $display("short press: rejected");
        // Pointer is 4 from the previous grant; an aborted debounce of key 5
        // must not move it, so keys {5,7} must grant 5 (7 if it moved to 6).
        bus.key = 10'h0A0;
        exp_q.push_back('{code: 4'd5, multi: 1'b1});
        wait_valid(40, edges);
        e = exp_q.pop_front();
        checks++; if (bus.valid !== 1'b1 || bus.code !== e.code) begin errors++; $display("FAIL short_ptr_code: got valid=%b code=%0d want valid=1 code=%0d", bus.valid, bus.code, e.code); end
        checks++; if (bus.multi !== e.multi) begin errors++; $display("FAIL short_ptr_multi: got %b want %b", bus.multi, e.multi); end
        $display("grant: code=%0d gnt=%03h multi=%b", bus.code, bus.gnt, bus.multi);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        bus.key = '0;
        wait_idle(40, edges);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL short_ptr_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_round_robin();
        int         edges;
        exp_t       e;
        logic [3:0] exp_codes[3];
        exp_codes[0] = 4'd0;
        exp_codes[1] = 4'd9;
        exp_codes[2] = 4'd0;
        // Start from PTR=0.
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            bus.key = 10'h201;
            exp_q.push_back('{code: exp_codes[i], multi: 1'b1});
            wait_valid(40, edges);
            e = exp_q.pop_front();
            checks++; if (bus.valid !== 1'b1 || bus.code !== e.code) begin errors++; $display("FAIL rr_code[%0d]: got valid=%b code=%0d want valid=1 code=%0d", i, bus.valid, bus.code, e.code); end
            checks++; if (bus.gnt !== (10'd1 << e.code)) begin errors++; $display("FAIL rr_gnt[%0d]: got %03h want %03h", i, bus.gnt, 10'd1 << e.code); end
            checks++; if (bus.multi !== e.multi) begin errors++; $display("FAIL rr_multi[%0d]: got %b want %b", i, bus.multi, e.multi); end
            $display("grant: code=%0d gnt=%03h multi=%b", bus.code, bus.gnt, bus.multi);
            bus.ack = 1'b1;
            step(1);
            bus.ack = 1'b0;
            bus.key = '0;
            wait_idle(40, edges);
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle[%0d]: got busy=%b want 0", i, bus.busy); end
        end
    endtask

    task automatic test_hold_stable();
        int   edges;
        exp_t e;
        bus.key = 10'h100;
        exp_q.push_back('{code: 4'd8, multi: 1'b0});
        wait_valid(40, edges);
        e = exp_q.pop_front();
        checks++; if (bus.valid !== 1'b1 || bus.code !== e.code) begin errors++; $display("FAIL hold_code: got valid=%b code=%0d want valid=1 code=%0d", bus.valid, bus.code, e.code); end
        $display("grant: code=%0d gnt=%03h multi=%b", bus.code, bus.gnt, bus.multi);
        for (int i = 0; i < 20; i++) begin
            bus.key = 10'($urandom_range(0, 1023));
            step(1);
            checks++;
            if (bus.valid !== 1'b1 || bus.gnt !== (10'd1 << e.code) || bus.code !== e.code) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid=%b gnt=%03h code=%0d want valid=1 gnt=%03h code=%0d",
                         i, bus.valid, bus.gnt, bus.code, 10'd1 << e.code, e.code);
            end
        end
        bus.key = '0;
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        wait_idle(40, edges);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_ack_ignored();
        bus.ack = 1'b1;
        step(3);
        bus.ack = 1'b0;
        step(1);
        checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL ack_idle: got busy=%b valid=%b want 0 0", bus.busy, bus.valid); end
        $display("ack in idle: ignored");
    endtask

    task automatic test_reset_in_hold();
        int   edges;
        exp_t e;
        // PTR is 9 here; key 2 is alone so it wins regardless.
        bus.key = 10'h004;
        exp_q.push_back('{code: 4'd2, multi: 1'b0});
        wait_valid(40, edges);
        e = exp_q.pop_front();
        checks++; if (bus.valid !== 1'b1 || bus.code !== e.code) begin errors++; $display("FAIL rst_hold_code: got valid=%b code=%0d want valid=1 code=%0d", bus.valid, bus.code, e.code); end
        $display("grant: code=%0d gnt=%03h multi=%b", bus.code, bus.gnt, bus.multi);
        #2;
        rst_n = 1'b0;
        #1;
        // Still before the next rising edge.
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", bus.valid); end
        checks++; if (bus.gnt !== 10'h000) begin errors++; $display("FAIL rst_async_gnt: got %03h want 000", bus.gnt); end
        checks++; if (bus.code !== 4'd0) begin errors++; $display("FAIL rst_async_code: got %0d want 0", bus.code); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        bus.key = '0;
        rst_n   = 1'b1;
        step(2);
        // PTR was 9 before reset; after reset keys {0,9} must grant 0.
        bus.key = 10'h201;
        exp_q.push_back('{code: 4'd0, multi: 1'b1});
        wait_valid(40, edges);
        e = exp_q.pop_front();
        checks++; if (bus.valid !== 1'b1 || bus.code !== e.code) begin errors++; $display("FAIL rst_ptr_code: got valid=%b code=%0d want valid=1 code=%0d", bus.valid, bus.code, e.code); end
        $display("grant: code=%0d gnt=%03h multi=%b", bus.code, bus.gnt, bus.multi);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        bus.key = '0;
        wait_idle(40, edges);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_ptr_idle: got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_release_bounce();
        int   edges;
        exp_t e;
        bus.key = 10'h040;
        exp_q.push_back('{code: 4'd6, multi: 1'b0});
        wait_valid(40, edges);
        e = exp_q.pop_front();
        checks++; if (bus.valid !== 1'b1 || bus.code !== e.code) begin errors++; $display("FAIL bounce_code: got valid=%b code=%0d want valid=1 code=%0d", bus.valid, bus.code, e.code); end
        $display("grant: code=%0d gnt=%03h multi=%b", bus.code, bus.gnt, bus.multi);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        step(2);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bounce_held: got busy=%b want 1", bus.busy); end
        // Two low cycles, one high glitch, then low for good: the release
        // window restarts, so idle comes DEB_N+2 edges after the final drop.
        bus.key = '0;
        step(2);
        bus.key = 10'h040;
        step(1);
        bus.key = '0;
        wait_idle(40, edges);
        checks++; if (edges !== DEB_N + 2) begin errors++; $display("FAIL bounce_release: got %0d edges want %0d", edges, DEB_N + 2); end
        $display("release after bounce: idle after %0d edges", edges);
    endtask

    initial begin
        bus.key = '0;
        bus.ack = 1'b0;
        test_reset();
        test_single_press();
        test_short_press();
        test_round_robin();
        test_hold_stable();
        test_ack_ignored();
        test_reset_in_hold();
        test_release_bounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
